// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM states, reset-cause codes and
// the sizing function for the hold/release counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ASSERT  = 2'b01,
    RELEASE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_SW  = 2'b01,
    CAUSE_WDT = 2'b10
  } cause_e;

  // The counter must reach the longer of the hold phase and the full release span.
  function automatic int cnt_width(input int hold_cycles, input int release_span);
    int longest;
    longest = (hold_cycles > release_span) ? hold_cycles : release_span;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/reset_seq_wdt.sv
// Watchdog for the reset sequencer: counts idle cycles without a kick and flags the
// cycle on which the next edge must start a watchdog reset (used with RESET_SEQ_WDT_EN).
module reset_seq_wdt #(
  parameter int WDT_TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic in_idle,
  input  logic kick,
  output logic timeout
);

  localparam int W = $clog2(WDT_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(WDT_TIMEOUT - 1);

  logic [W-1:0] wdt_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wdt_cnt <= '0;
    end else if (!in_idle || kick) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != LAST) begin
      wdt_cnt <= wdt_cnt + W'(1);
    end
  end

  // A kick in the final cycle still rescues the system.
  assign timeout = in_idle && !kick && (wdt_cnt == LAST);

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges power-on, soft-reset and optional watchdog (RESET_SEQ_WDT_EN)
// resets into one hold-then-staggered-release sequence over NUM_DOMAINS reset domains.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
`ifdef RESET_SEQ_WDT_EN
  , parameter int WDT_TIMEOUT  = 1024
`endif
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
`ifdef RESET_SEQ_WDT_EN
  input  logic                   WDT_KICK,
`endif
  output logic                   SW_RST_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SYS_READY,
  output logic [1:0]             RST_CAUSE
);

  localparam int CW = cnt_width(HOLD_CYCLES, NUM_DOMAINS * STAGGER_CYCLES);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] READY_AT  = CW'(NUM_DOMAINS * STAGGER_CYCLES);

  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          ack_pend;
  logic          wdt_timeout;

  assign cnt_inc = cnt + CW'(1);

`ifdef RESET_SEQ_WDT_EN
  reset_seq_wdt #(
    .WDT_TIMEOUT (WDT_TIMEOUT)
  ) u_wdt (
    .CLK     (CLK),
    .RST     (RST),
    .in_idle (state == IDLE),
    .kick    (WDT_KICK),
    .timeout (wdt_timeout)
  );
`else
  assign wdt_timeout = 1'b0;
`endif

  // NOTE: non-blocking assignments only, so every decision below sees pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ASSERT;
      cnt          <= '0;
      DOMAIN_RST_N <= '0;
      SYS_READY    <= 1'b0;
      SW_RST_ACK   <= 1'b0;
      RST_CAUSE    <= CAUSE_POR;
      ack_pend     <= 1'b0;
    end else begin
      SW_RST_ACK <= 1'b0;
      // A soft request restarts the sequence from any state, even on the completion edge.
      if (SW_RST_REQ) begin
        state        <= ASSERT;
        cnt          <= '0;
        DOMAIN_RST_N <= '0;
        SYS_READY    <= 1'b0;
        RST_CAUSE    <= CAUSE_SW;
        ack_pend     <= 1'b1;
      end else if (wdt_timeout) begin
        state        <= ASSERT;
        cnt          <= '0;
        DOMAIN_RST_N <= '0;
        SYS_READY    <= 1'b0;
        RST_CAUSE    <= CAUSE_WDT;
      end else begin
        case (state)
          IDLE: ;
          ASSERT: begin
            if (cnt == HOLD_LAST) begin
              cnt             <= '0;
              state           <= RELEASE;
              DOMAIN_RST_N[0] <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          RELEASE: begin
            cnt <= cnt_inc;
            for (int k = 1; k < NUM_DOMAINS; k++) begin
              if (cnt_inc == CW'(k * STAGGER_CYCLES)) DOMAIN_RST_N[k] <= 1'b1;
            end
            if (cnt_inc == READY_AT) begin
              state      <= IDLE;
              cnt        <= '0;
              SYS_READY  <= 1'b1;
              SW_RST_ACK <= ack_pend;
              ack_pend   <= 1'b0;
            end
          end
          default: state <= ASSERT;
        endcase
      end
    end
  end

endmodule
